md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Sequences the shared multiply/divide resource for the P7 pipeline (E stage).
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, models the fixed busy latency and owns HI/LO.
//  Raises a stall to the D stage while a later HI/LO-using instr must wait.
//  HI/LO feed the E-stage result path, which reaches the writeback mux as ALUout.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after MULT/MULTU issue (>=1)
//  DIV_CYCLES   10  busy cycles after DIV/DIVU issue (>=1)
// PORTS
//  clk       in   1   sole clock, rising edge
//  reset     in   1   synchronous, active-high
//  Start_E   in   1   E-stage instr is an MD op this cycle
//  MDOp_E    in   3   op code: MULT/MULTU/DIV/DIVU/MTHI/MTLO (md_def.v)
//  A_E       in   32  rs operand
//  B_E       in   32  rt operand
//  Req       in   1   exception/interrupt flush this cycle
//  MDUse_D   in   1   D-stage instr is MD op or MFHI/MFLO
//  Busy      out  1   operation in flight
//  Stall_MD  out  1   = MDUse_D & (Start_E | Busy)
//  HI        out  32  HI register
//  LO        out  32  LO register
// BEHAVIOUR
//  - Single clock; reset is synchronous and active-high. Reset: Busy=0, count=0, HI=0, LO=0.
//  - States: IDLE (count==0), RUN (count>0). Busy = (count!=0).
//  - Accept = Start_E & ~Busy & ~Req. Start_E while Busy is a protocol error.
//    It cannot occur because Stall_MD holds it in D. The RTL ignores it.
//  - MULT/MULTU accepted at edge 0: latch 64-bit product in tmp_hi/tmp_lo.
//    Load count=MULT_CYCLES. Busy=1 in cycles 1..MULT_CYCLES.
//  - DIV/DIVU accepted: tmp_lo=quotient, tmp_hi=remainder. Load count=DIV_CYCLES.
//  - Signed ops use $signed. Quotient truncates toward zero; remainder takes the sign of the dividend.
//    Example: -7/2 -> LO=-3, HI=-1.
//  - RUN: count decrements each edge. At the edge where count goes 1->0:
//    HI<=tmp_hi, LO<=tmp_lo. New HI/LO are visible in the cycle Busy falls.
//  - Div by zero: operation still busy for DIV_CYCLES. HI/LO are left unchanged at completion.
//  - MTHI/MTLO accepted: HI (or LO) <= A_E at the next edge. Busy stays 0.
//  - Req=1 with Start_E=1: no accept, no state change.
//    Req while RUN: the in-flight op completes normally. It issued before the flush.
//  - Reset mid-RUN: count=0 and HI/LO=0 at that edge. Pending result is discarded.
//  - Back-to-back: a new Start_E is accepted in the first cycle Busy=0.
//  - Stall_MD is combinational. There is no other combinational path from inputs to outputs.
// STRUCTURE
//  - md_def.v (include-guarded like other shared headers) holds the MDOp encodings.
//    Encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
//    The same header holds MFHI/MFLO select constants, shared with ctrl.v.
//  - One sub-module, md_calc: combinational; A, B, op -> {tmp_hi, tmp_lo}, div0 flag.
//  - Counter, HI/LO registers and stall logic stay in md_unit_ctrl.
// TESTING
//  1 reset=1 two cycles after MTHI of 5 -> HI=0, LO=0, Busy=0, Stall_MD=0.
//  2 MULT A=-3 B=4 -> Busy high exactly 5 cycles.
//    HI=0xFFFFFFFF, LO=0xFFFFFFF4 in the cycle Busy falls.
//  3 DIVU A=7 B=2 with MDUse_D=1 (MFLO in D) -> Stall_MD=1 for issue cycle + 10 busy cycles.
//    Then LO=3, HI=1, Stall_MD=0.
//  4 DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIV A=9 B=0 -> 10 busy cycles, HI/LO unchanged.
//  5 Start_E=1 with Req=1 (MULT 2*3) -> Busy stays 0, HI/LO unchanged.
//    Req asserted mid-MULT -> result still committed.
//  6 MULTU 0xFFFFFFFF*2, reset asserted at busy cycle 3 -> Busy=0, HI=LO=0.
//    Then MTLO 0x1234 -> LO=0x1234 next cycle, Busy=0.

Source files
------------

// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// MFHI/MFLO selects, FSM states and the HI/LO result payload.
package md_unit_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  // Result-path selects for MFHI/MFLO, shared with the decoder
  localparam logic [1:0] MF_SEL_ALU = 2'd0;
  localparam logic [1:0] MF_SEL_HI  = 2'd1;
  localparam logic [1:0] MF_SEL_LO  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_pair_t;

endpackage

// File: rtl/md_unit_ctrl_md_calc.sv
// Combinational multiply/divide datapath: produces the {HI, LO} pair for
// MULT/MULTU/DIV/DIVU and flags division by zero.
module md_calc
  import md_unit_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output md_pair_t          res,
  output logic              div0
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;

  // Low 64 bits of a product of sign-extended operands are the signed product
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    res  = '0;
    div0 = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (b == '0) begin
          div0 = 1'b1;
        end else begin
          res.lo = $signed(a) / $signed(b);
          res.hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          div0 = 1'b1;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models the fixed busy
// latency and stalls D-stage HI/LO users while a result is pending.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start_E,
  input  logic [OP_W-1:0]   MDOp_E,
  input  logic [DATA_W-1:0] A_E,
  input  logic [DATA_W-1:0] B_E,
  input  logic              Req,
  input  logic              MDUse_D,
  output logic              Busy,
  output logic              Stall_MD,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  md_pair_t          tmp_q, tmp_d;
  logic              skip_q, skip_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  md_pair_t          calc_res;
  logic              calc_div0;
  logic              accept;

  md_calc u_calc (
    .a    (A_E),
    .b    (B_E),
    .op   (MDOp_E),
    .res  (calc_res),
    .div0 (calc_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tmp_q   <= '0;
      skip_q  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmp_q   <= tmp_d;
      skip_q  <= skip_d;
      HI      <= hi_d;
      LO      <= lo_d;
    end
  end

  // A flushed instruction never issues; Start_E while busy cannot happen and is ignored
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmp_d   = tmp_q;
    skip_d  = skip_q;
    hi_d    = HI;
    lo_d    = LO;
    accept  = Start_E & ~Req & (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (MDOp_E)
            MD_MULT, MD_MULTU: begin
              state_d = RUN;
              count_d = CNT_W'(MULT_CYCLES);
              tmp_d   = calc_res;
              skip_d  = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d = RUN;
              count_d = CNT_W'(DIV_CYCLES);
              tmp_d   = calc_res;
              skip_d  = calc_div0;
            end
            MD_MTHI: hi_d = A_E;
            MD_MTLO: lo_d = A_E;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_d = count_q - CNT_W'(1);
        // Divide-by-zero still burns its latency but leaves HI/LO untouched
        if (count_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!skip_q) begin
            hi_d = tmp_q.hi;
            lo_d = tmp_q.lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy     = (state_q == RUN);
  assign Stall_MD = MDUse_D & (Start_E | Busy);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed + randomized bench for md_unit_ctrl with a result scoreboard.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Start_E, Req, MDUse_D;
  logic [2:0]  MDOp_E;
  logic [31:0] A_E, B_E;
  logic        Busy, Stall_MD;
  logic [31:0] HI, LO;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start_E  (Start_E),
    .MDOp_E   (MDOp_E),
    .A_E      (A_E),
    .B_E      (B_E),
    .Req      (Req),
    .MDUse_D  (MDUse_D),
    .Busy     (Busy),
    .Stall_MD (Stall_MD),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl_hi   = '0;
  logic [31:0] mdl_lo   = '0;
  int          busy_n, stall_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.cycles = cycles;
    sb.push_back(e);
  endtask

  // Called at a negedge: present the op for one cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    Start_E = 1'b1; MDOp_E = op; A_E = a; B_E = b; Req = req;
    @(negedge clk);
    Start_E = 1'b0; Req = 1'b0;
  endtask

  // Count busy cycles (bounded), optionally pulse Req mid-flight, then score
  task automatic wait_done(input int req_at);
    exp_t e;
    busy_n = 0; stall_n = 0;
    while (Busy === 1'b1 && busy_n < 50) begin
      busy_n++;
      if (Stall_MD === 1'b1) stall_n++;
      Req = (busy_n == req_at);
      @(negedge clk);
    end
    Req = 1'b0;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, "_cycles"}, 32'(busy_n), 32'(e.cycles));
    check({e.tag, "_hi"}, HI, e.hi);
    check({e.tag, "_lo"}, LO, e.lo);
    check({e.tag, "_busy_low"}, 32'(Busy), 32'd0);
    mdl_hi = e.hi;
    mdl_lo = e.lo;
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.tag = ""; e.hi = mdl_hi; e.lo = mdl_lo;
    e.cycles = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
    case (op)
      MD_MULT: begin
        p = 64'(longint'(int'(a)) * longint'(int'(b)));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_MULTU: begin
        p = 64'(a) * 64'(b);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_DIV: if (b != 0) begin
        e.lo = 32'(int'(a) / int'(b));
        e.hi = 32'(int'(a) % int'(b));
      end
      default: if (b != 0) begin
        e.lo = a / b;
        e.hi = a % b;
      end
    endcase
    return e;
  endfunction

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    exp_t e;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; Start_E = 1'b0; Req = 1'b0; MDUse_D = 1'b0;
    MDOp_E = '0; A_E = '0; B_E = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_stall", 32'(Stall_MD), 32'd0);
    reset = 1'b0;

    // MTHI then reset clears it
    issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
    check("mthi_hi", HI, 32'd5);
    check("mthi_busy", 32'(Busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst2_hi", HI, 32'd0);
    check("rst2_lo", LO, 32'd0);
    check("rst2_busy", 32'(Busy), 32'd0);
    check("rst2_stall", 32'(Stall_MD), 32'd0);
    mdl_hi = '0; mdl_lo = '0;

    // MULT -3*4
    push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd4, 1'b0);
    wait_done(-1);

    // DIVU 7/2 back-to-back, with MFLO waiting in D
    MDUse_D = 1'b1;
    Start_E = 1'b1; MDOp_E = MD_DIVU; A_E = 32'd7; B_E = 32'd2;
    push("divu", 32'd1, 32'd3, 10);
    #1;
    check("stall_issue", 32'(Stall_MD), 32'd1);
    @(negedge clk);
    Start_E = 1'b0;
    wait_done(-1);
    check("stall_total", 32'(stall_n + 1), 32'd11);
    check("stall_release", 32'(Stall_MD), 32'd0);
    MDUse_D = 1'b0;

    // Signed divide, then divide by zero keeps HI/LO
    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(-1);
    push("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'd9, 32'd0, 1'b0);
    wait_done(-1);

    // Flushed issue is dropped; Req mid-flight does not cancel
    issue(MD_MULT, 32'd2, 32'd3, 1'b1);
    check("req_busy", 32'(Busy), 32'd0);
    check("req_hi", HI, mdl_hi);
    check("req_lo", LO, mdl_lo);
    push("mult_req_mid", 32'd0, 32'd6, 5);
    issue(MD_MULT, 32'd2, 32'd3, 1'b0);
    wait_done(2);

    push("multu", 32'd1, 32'hFFFF_FFFE, 5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(-1);

    // Reset at busy cycle 3 discards the pending product
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_busy3", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    issue(MD_MTLO, 32'h1234, 32'd0, 1'b0);
    check("mtlo_lo", LO, 32'h1234);
    check("mtlo_busy", 32'(Busy), 32'd0);
    repeat (6) @(negedge clk);
    check("discard_hi", HI, 32'd0);
    check("discard_busy", 32'(Busy), 32'd0);
    mdl_hi = '0; mdl_lo = 32'h1234;

    // Randomized back-to-back ops checked against the reference model
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (rop >= MD_DIV) ? 32'($urandom_range(1, 1000)) : $urandom;
      e = model(rop, ra, rb);
      push($sformatf("rnd%0d", i), e.hi, e.lo, e.cycles);
      issue(rop, ra, rb, 1'b0);
      wait_done(-1);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
